// File: rtl/bootrom_copier_if.sv
// SRAM write port of the boot ROM copier: registered address/data with a
// request held until the memory acknowledges it.
interface bootrom_copier_if #(
  parameter int ADDR_W = 21
);
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_dout;
  logic              mem_we;
  logic              mem_ack;

  modport master (
    output mem_addr,
    output mem_dout,
    output mem_we,
    input  mem_ack
  );

  modport slave (
    input  mem_addr,
    input  mem_dout,
    input  mem_we,
    output mem_ack
  );
endinterface

// File: rtl/bootrom_copier.sv
// Boot-time copier: streams a byte range of the synchronous boot ROM into
// SRAM as the shadow DivMMC page, holding the Z80 in reset until done.
module bootrom_copier #(
  parameter int                ADDR_W    = 21,
  parameter int                SRC_START = 512,
  parameter int                LENGTH    = 8192,
  parameter logic [ADDR_W-1:0] DST_BASE  = 21'h040000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [13:0]      rom_a,
  input  logic [7:0]       rom_dout,
  bootrom_copier_if.master mem,
  output logic             busy,
  output logic             done,
  output logic             cpu_hold,
  output logic [15:0]      checksum
);

  generate
    if (SRC_START < 0 || SRC_START > 16383 || LENGTH < 0 ||
        SRC_START + LENGTH > 16384) begin : g_bad_range
      $error("bootrom_copier: source range exceeds the 16 KiB ROM");
    end
  endgenerate

  localparam logic [13:0] SRC_A = 14'(SRC_START);
  localparam logic [14:0] LEN_C = 15'(LENGTH);

  typedef enum logic [2:0] {IDLE, ROMWAIT, CAPTURE, WRITE, FINISH} state_t;

  state_t      state_reg;
  logic [14:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      rom_a        <= SRC_A;
      mem.mem_addr <= DST_BASE;
      mem.mem_dout <= '0;
      mem.mem_we   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cpu_hold     <= 1'b1;
      checksum     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            count_reg    <= LEN_C;
            rom_a        <= SRC_A;
            mem.mem_addr <= DST_BASE;
            checksum     <= '0;
            done         <= 1'b0;
            busy         <= 1'b1;
            state_reg    <= (LENGTH == 0) ? FINISH : ROMWAIT;
          end
        end
        // ROM registers rom_a on this state's exit edge
        ROMWAIT: state_reg <= CAPTURE;
        CAPTURE: begin
          mem.mem_dout <= rom_dout;
          checksum     <= checksum + {8'h00, rom_dout};
          mem.mem_we   <= 1'b1;
          state_reg    <= WRITE;
        end
        WRITE: begin
          if (mem.mem_we && mem.mem_ack) begin
            mem.mem_we <= 1'b0;
            count_reg  <= count_reg - 15'd1;
            if (count_reg == 15'd1) begin
              state_reg <= FINISH;
            end else begin
              rom_a        <= rom_a + 14'd1;
              mem.mem_addr <= mem.mem_addr + ADDR_W'(1);
              state_reg    <= ROMWAIT;
            end
          end
        end
        FINISH: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          cpu_hold  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bootrom_copier.md
Name: bootrom_copier

Overview:
- Boot-time DMA engine directly downstream of the 14-bit synchronous boot/DivMMC ROM.
- On a start pulse it reads a contiguous byte range from the ROM and writes it, one byte per handshake, into external SRAM.
- The SRAM copy then serves as the shadow DivMMC ROM page.
- Holds the Z80 in reset while copying and reports a 16-bit additive checksum of the bytes written.

Parameters:
- SRC_START, 512, first ROM byte address copied (0..16383)
- LENGTH, 8192, number of bytes copied (0..16384); SRC_START+LENGTH must not exceed 16384, enforced by an elaboration-time check
- DST_BASE, 21'h040000, SRAM byte address receiving ROM byte SRC_START
- ADDR_W, 21, SRAM address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin a copy
- rom_a  out  14  ROM address, registered
- rom_dout  in  8  ROM data; valid 1 cycle after ROM samples rom_a (ROM registers on posedge clk)
- mem_addr  out  ADDR_W  SRAM write address, registered
- mem_dout  out  8  SRAM write data, registered
- mem_we  out  1  write request, held until acknowledged
- mem_ack  in  1  SRAM write accepted
- busy  out  1  copy in progress
- done  out  1  last copy completed; sticky
- cpu_hold  out  1  Z80 reset request; high from reset until first copy completes
- checksum  out  16  sum mod 2^16 of all bytes written in the current/last copy

Behaviour:
- Clock: one clock, clk. Reset: rst_n, synchronous, active-low.
- Reset values, all outputs: rom_a=SRC_START, mem_addr=DST_BASE, mem_dout=0, mem_we=0, busy=0, done=0, cpu_hold=1, checksum=0.
- Reset mid-copy aborts immediately, with no further mem_we. cpu_hold returns to 1.
- FSM states: IDLE, ROMWAIT, CAPTURE, WRITE, FINISH.
- Internal count register, 15 bits: remaining bytes.
- IDLE:
  - start=1 loads count=LENGTH, rom_a=SRC_START, mem_addr=DST_BASE, checksum=0, done=0, busy=1.
  - If LENGTH=0, go to FINISH; otherwise go to ROMWAIT.
  - start=0: stay.
- ROMWAIT: exactly one cycle. The ROM samples rom_a at this state's exit edge.
- CAPTURE:
  - mem_dout<=rom_dout; checksum<=checksum+rom_dout.
  - mem_we<=1; go to WRITE.
  - rom_dout is thus sampled exactly 2 edges after rom_a was updated.
- WRITE:
  - mem_addr and mem_dout are stable while mem_we=1.
  - At an edge with mem_we=1 and mem_ack=1: mem_we<=0, count<=count-1.
    - If count==1, go to FINISH.
    - Otherwise rom_a<=rom_a+1, mem_addr<=mem_addr+1, go to ROMWAIT.
  - mem_ack while mem_we=0 is ignored.
  - No timeout; waits indefinitely.
- FINISH: busy<=0, done<=1, cpu_hold<=0; go to IDLE.
- Minimum per byte: 3 cycles (ROMWAIT, CAPTURE, WRITE with immediate ack).
  - N bytes with mem_ack tied high: busy high for 3N+1 cycles. LENGTH=0: 1 cycle.
- start while busy=1 is ignored; the copy in progress is unaffected.
- start with done=1 re-runs the copy: done clears, checksum restarts.
  - cpu_hold stays 0 after the first completion; it is set only by reset.
- Address arithmetic:
  - rom_a never passes SRC_START+LENGTH-1, so there is no 14-bit wrap.
  - mem_addr increments modulo 2^ADDR_W; wrap past all-ones is legal.
- checksum wraps modulo 65536. It holds its final value until the next start or reset.

Test Plan:
- SRC_START=512, LENGTH=4, ROM[512..515]=11,22,33,44 hex, mem_ack tied 1.
  - Expect 4 writes: addr 040000..040003 hex, data 11,22,33,44.
  - busy high 13 cycles; done=1, cpu_hold=0, checksum=00AA hex.
- Same setup, mem_ack delayed 5 cycles per write.
  - mem_we held high with addr/data stable each time; exactly 4 writes; no duplicate on a late ack.
- LENGTH=0, start pulse.
  - busy high 1 cycle, no mem_we, done=1, checksum=0.
- LENGTH=3, all ROM bytes FF hex, DST_BASE=1FFFFF hex.
  - Writes to 1FFFFF, 000000, 000001; checksum=02FD hex.
- Mid-copy (after 2nd ack of LENGTH=4), assert rst_n=0 for 1 cycle.
  - mem_we drops next edge; cpu_hold=1, done=0, checksum=0.
  - A new start then copies all 4 bytes again from 040000 hex.
- start pulsed during WRITE → ignored.
  - start after done → second identical copy, done low during it, cpu_hold stays 0.
